// File: rtl/bin2bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef logic [3:0] bcd_digit_t;

    // Smallest digit count whose decimal range covers every WIDTH-bit value.
    function automatic int min_digits(input int width);
        longint unsigned maxVal;
        longint unsigned pow10;
        int              digits;
        maxVal = (64'd1 << width) - 64'd1;
        pow10  = 64'd10;
        digits = 1;
        while (pow10 <= maxVal) begin
            pow10  = pow10 * 64'd10;
            digits = digits + 1;
        end
        return digits;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  bcd_digit_t digit_i,
    output bcd_digit_t digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one operand bit per clock,
// with valid/ready handshakes on the operand and result sides.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    if (WIDTH < 1 || WIDTH > 32 || DIGITS < min_digits(WIDTH)) begin : g_param_check
        $error("bin2bcd_seq: illegal WIDTH/DIGITS combination");
    end

    state_e          state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [SW-1:0]   scratch_q, scratch_d;
    logic [SW-1:0]   bcd_q, bcd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   adjusted;
    logic            lastStep;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (scratch_q[4*g +: 4]),
            .digit_o (adjusted[4*g +: 4])
        );
    end

    assign lastStep = (cnt_q == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = SHIFT;
            SHIFT:   if (lastStep)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The final step's shifted scratch is the finished result, so it goes straight into bcd.
    always_comb begin
        shift_d   = shift_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d   = bin;
                    scratch_d = '0;
                    cnt_d     = CW'(WIDTH);
                end
            end
            SHIFT: begin
                shift_d   = shift_q << 1;
                scratch_d = (adjusted << 1) | SW'(shift_q[WIDTH-1]);
                cnt_d     = cnt_q - CW'(1);
                if (lastStep) begin
                    bcd_d = scratch_d;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE:  in_ready = 1'b1;
            SHIFT: busy     = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    assign bcd = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: an 8-bit and a 16-bit instance checked against a decimal model.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;

    always @(posedge clk) cycle++;

    logic        rst8 = 1'b1, inValid8 = 1'b0, outReady8 = 1'b0;
    logic        inReady8, outValid8, busy8;
    logic [7:0]  bin8 = '0;
    logic [11:0] bcd8;

    logic        rst16 = 1'b1, inValid16 = 1'b0, outReady16 = 1'b0;
    logic        inReady16, outValid16, busy16;
    logic [15:0] bin16 = '0;
    logic [19:0] bcd16;

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut8 (
        .clk(clk), .rst(rst8), .in_valid(inValid8), .in_ready(inReady8), .bin(bin8),
        .out_valid(outValid8), .out_ready(outReady8), .bcd(bcd8), .busy(busy8)
    );

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut16 (
        .clk(clk), .rst(rst16), .in_valid(inValid16), .in_ready(inReady16), .bin(bin16),
        .out_valid(outValid16), .out_ready(outReady16), .bcd(bcd16), .busy(busy16)
    );

    function automatic logic [19:0] toBcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    // Behavioural model: an accepted operand yields its decimal value WIDTH edges later,
    // which is then held until the consumer takes it.
    logic        m8Live = 1'b0, m8Idle = 1'b1, m8Valid = 1'b0;
    int          m8Count = 0;
    logic [7:0]  m8Pend = '0;
    logic [19:0] m8Bcd = '0;

    always @(posedge clk) begin
        if (rst8) begin
            m8Live = 1'b1; m8Idle = 1'b1; m8Valid = 1'b0; m8Count = 0; m8Bcd = '0;
        end else if (m8Live) begin
            if (m8Idle && inValid8) begin
                m8Idle = 1'b0; m8Count = 8; m8Pend = bin8;
            end else if (m8Count > 0) begin
                m8Count--;
                if (m8Count == 0) begin
                    m8Valid = 1'b1;
                    m8Bcd   = toBcd(32'(m8Pend));
                end
            end else if (m8Valid && outReady8) begin
                m8Valid = 1'b0; m8Idle = 1'b1;
            end
        end
    end

    logic        m16Live = 1'b0, m16Idle = 1'b1, m16Valid = 1'b0;
    int          m16Count = 0;
    logic [15:0] m16Pend = '0;
    logic [19:0] m16Bcd = '0;

    always @(posedge clk) begin
        if (rst16) begin
            m16Live = 1'b1; m16Idle = 1'b1; m16Valid = 1'b0; m16Count = 0; m16Bcd = '0;
        end else if (m16Live) begin
            if (m16Idle && inValid16) begin
                m16Idle = 1'b0; m16Count = 16; m16Pend = bin16;
            end else if (m16Count > 0) begin
                m16Count--;
                if (m16Count == 0) begin
                    m16Valid = 1'b1;
                    m16Bcd   = toBcd(32'(m16Pend));
                end
            end else if (m16Valid && outReady16) begin
                m16Valid = 1'b0; m16Idle = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m8Live) begin
            checkOutput("w8_in_ready",  32'(inReady8),  32'(m8Idle));
            checkOutput("w8_out_valid", 32'(outValid8), 32'(m8Valid));
            checkOutput("w8_busy",      32'(busy8),     32'(!m8Idle));
            checkOutput("w8_bcd",       32'(bcd8),      32'(m8Bcd[11:0]));
        end
        if (m16Live) begin
            checkOutput("w16_in_ready",  32'(inReady16),  32'(m16Idle));
            checkOutput("w16_out_valid", 32'(outValid16), 32'(m16Valid));
            checkOutput("w16_busy",      32'(busy16),     32'(!m16Idle));
            checkOutput("w16_bcd",       32'(bcd16),      32'(m16Bcd));
        end
    end

    // Called #1 after an edge with the converter idle; checks exact latency and release.
    task automatic applyStimulus8(input logic [7:0] v, input logic [11:0] want, input string name);
        int guard;
        guard = 0;
        inValid8 = 1'b1;
        bin8     = v;
        while (!inReady8 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!inReady8) checkOutput({name, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        inValid8 = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        checkOutput({name, "_early_valid"}, 32'(outValid8), 32'd0);
        @(posedge clk); #1;
        checkOutput({name, "_valid"}, 32'(outValid8), 32'd1);
        checkOutput({name, "_bcd"},   32'(bcd8),      32'(want));
        outReady8 = 1'b1;
        @(posedge clk); #1;
        outReady8 = 1'b0;
        checkOutput({name, "_ready_after"}, 32'(inReady8), 32'd1);
    endtask

    task automatic applyStimulus16(input logic [15:0] v, input logic [19:0] want, input string name);
        int guard;
        guard = 0;
        inValid16 = 1'b1;
        bin16     = v;
        while (!inReady16 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!inReady16) checkOutput({name, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        inValid16 = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checkOutput({name, "_early_valid"}, 32'(outValid16), 32'd0);
        @(posedge clk); #1;
        checkOutput({name, "_valid"}, 32'(outValid16), 32'd1);
        checkOutput({name, "_bcd"},   32'(bcd16),      32'(want));
        outReady16 = 1'b1;
        @(posedge clk); #1;
        outReady16 = 1'b0;
        checkOutput({name, "_ready_after"}, 32'(inReady16), 32'd1);
    endtask

    logic [11:0] walkWant [8] = '{12'h001, 12'h002, 12'h004, 12'h008,
                                  12'h016, 12'h032, 12'h064, 12'h128};

    initial begin
        int guard;
        int lastAccept;

        checkOutput("model_pin_255",   32'(toBcd(255)),   32'h00255);
        checkOutput("model_pin_10000", 32'(toBcd(10000)), 32'h10000);
        checkOutput("model_pin_99",    32'(toBcd(99)),    32'h00099);

        repeat (3) @(posedge clk);
        #1;
        rst8  = 1'b0;
        rst16 = 1'b0;
        checkOutput("reset_in_ready",  32'(inReady8),  32'd1);
        checkOutput("reset_out_valid", 32'(outValid8), 32'd0);
        checkOutput("reset_busy",      32'(busy8),     32'd0);
        checkOutput("reset_bcd",       32'(bcd8),      32'd0);
        checkOutput("reset_bcd16",     32'(bcd16),     32'd0);

        applyStimulus8(8'h00, 12'h000, "zero");

        for (int i = 0; i < 8; i++) begin
            applyStimulus8(8'(1 << i), walkWant[i], $sformatf("walk%0d", i));
        end

        // Result held with the consumer stalled; operands offered meanwhile must be dropped.
        inValid8 = 1'b1;
        bin8     = 8'hFF;
        @(posedge clk); #1;
        inValid8 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            checkOutput("hold_valid", 32'(outValid8), 32'd1);
            checkOutput("hold_bcd",   32'(bcd8),      32'h255);
            inValid8 = (i % 3 == 0) && (i < 19);
            bin8     = 8'h11;
            @(posedge clk); #1;
        end
        inValid8  = 1'b0;
        outReady8 = 1'b1;
        @(posedge clk); #1;
        outReady8 = 1'b0;
        checkOutput("hold_release_ready", 32'(inReady8), 32'd1);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("hold_no_ghost", 32'(outValid8), 32'd0);

        // Abort mid-conversion.
        inValid8 = 1'b1;
        bin8     = 8'h63;
        @(posedge clk); #1;
        inValid8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst8 = 1'b1;
        @(posedge clk); #1;
        rst8 = 1'b0;
        checkOutput("abort_in_ready",  32'(inReady8),  32'd1);
        checkOutput("abort_out_valid", 32'(outValid8), 32'd0);
        checkOutput("abort_bcd",       32'(bcd8),      32'd0);
        checkOutput("abort_busy",      32'(busy8),     32'd0);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("abort_no_result", 32'(outValid8), 32'd0);
        applyStimulus8(8'h63, 12'h099, "after_abort");

        applyStimulus16(16'hFFFF, 20'h65535, "max16");
        applyStimulus16(16'h2710, 20'h10000, "ten_thousand");

        // Back-to-back operands with the consumer always ready.
        outReady16 = 1'b1;
        bin16      = 16'd9999;
        inValid16  = 1'b1;
        lastAccept = -1;
        for (int n = 0; n < 10; n++) begin
            guard = 0;
            while (!inReady16 && guard < 100) begin
                @(posedge clk); #1;
                guard++;
            end
            if (!inReady16) begin
                checkOutput("rand_accept_timeout", 32'd0, 32'd1);
                break;
            end
            @(posedge clk); #1;
            if (lastAccept >= 0) checkOutput("rand_gap", 32'(cycle - lastAccept), 32'd18);
            lastAccept = cycle;
            bin16 = 16'($urandom);
        end
        inValid16 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("rand_drained", 32'(outValid16), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
